snake_game_sequencer: RTL
=========================

# snake_game_sequencer

Top-level game sequencer for the snake game. Owns the one-hot `Game_status` bus (START/PLAY/END) and the `Flash_sig` death-flash signal, both consumed by the snake control module. Generates the snake step strobe `Move_tick`, keeps score and speed level, and reacts to the wall and body hit flags returned by the snake control module.

## Interface
- `MOVE_DIV`, 12_500_000: initial clocks per snake step (4 steps/s at 50 MHz).
- `MIN_DIV`, 3_125_000: fastest allowed step period, in clocks.
- `DIV_STEP`, 1_250_000: step-period reduction per level-up.
- `APPLES_PER_LEVEL`, 4: apples required per level-up.
- `FLASH_DIV`, 12_500_000: clocks between `Flash_sig` toggles in DIE.
- `FLASH_TOGGLES`, 6: number of `Flash_sig` toggles before OVER.
- `Clk_50mhz  input  1`: system clock.
- `Rst_n  input  1`: reset, asynchronous and active-low.
- `Key_left`, `Key_right`, `Key_up`, `Key_down  input  1 each`: debounced key levels, synchronous to `Clk_50mhz`.
- `Body_add_sig  input  1`: apple-eaten flag; a level that may stay high for several cycles.
- `Hit_wall_sig  input  1`: snake head hit the wall.
- `Hit_body_sig  input  1`: snake head hit its own body.
- `Game_status  output  3`: one-hot game state. 3'b001 = START, 3'b010 = PLAY, 3'b100 = END.
- `Flash_sig  output  1`: blink control for the dead snake.
- `Move_tick  output  1`: one-cycle snake step strobe.
- `Score  output  8`: apples eaten; saturates at 255.
- `Level  output  4`: speed level; saturates at 15.

## Operation
- Internal states: START, PLAY, DIE, OVER.
  - `Game_status` = 001 in START, 010 in PLAY, 100 in both DIE and OVER.
- Key handling:
  - `any_key` = OR of the four key inputs.
  - The block registers `any_key` and acts only on its rising edge (`key_edge`).
  - It likewise registers `Body_add_sig` and uses its rising edge (`apple_edge`).
- START:
  - On `key_edge`, go to PLAY.
  - On the entry cycle: `Score` = 0, `Level` = 0, `cur_div` = `MOVE_DIV`, step counter = 0, apple counter = 0.
- PLAY:
  - The step counter increments every clock.
  - When `counter >= cur_div - 1`: the counter returns to 0 and `Move_tick` is 1 on the next cycle.
  - The `>=` comparison keeps a mid-period shrink of `cur_div` from skipping a tick.
- Apple handling in PLAY (on `apple_edge`):
  - `Score` += 1, saturating at 255.
  - The apple counter increments.
  - When the apple counter reaches `APPLES_PER_LEVEL`:
    - The apple counter returns to 0.
    - `Level` += 1, saturating at 15.
    - `cur_div` = max(`cur_div` − `DIV_STEP`, `MIN_DIV`).
  - The new `cur_div` applies from the following cycle.
- Hit handling in PLAY: `Hit_wall_sig | Hit_body_sig` sends the FSM to DIE on the next edge.
- Simultaneous events in PLAY:
  - Hit has priority: the apple is not counted and a pending `Move_tick` is suppressed.
  - Apple and step wrap together: both take effect.
- DIE:
  - `Move_tick` = 0.
  - The flash counter counts `FLASH_DIV` clocks, then toggles `Flash_sig`.
  - After `FLASH_TOGGLES` toggles, go to OVER with `Flash_sig` = 0.
  - Keys, hits and apples are ignored.
- OVER:
  - `Score` and `Level` hold.
  - On `key_edge`, go to START.
  - A key held across the DIE→OVER transition does not produce an edge.
- Asynchronous reset at any time, including mid-PLAY or mid-DIE: the FSM returns to START and every counter is cleared.

## Timing
- Reset values:
  - `Game_status` = 3'b001.
  - `Flash_sig` = 0, `Move_tick` = 0, `Score` = 0, `Level` = 0.
  - Internal key/apple history registers = 0.
- All outputs are registered; no combinational path runs from input to output.
- Latency from input to response:
  - `key_edge` → `Game_status` change: input sampled at edge N, `key_edge` valid in cycle N, `Game_status` updated at edge N+1.
  - Hit asserted in cycle N → `Game_status` = 100 from edge N+1.
  - `Body_add_sig` rising in cycle N → `Score` updated at edge N+1.
- `Move_tick` spacing:
  - The first tick comes `cur_div` cycles after PLAY entry.
  - Consecutive ticks are exactly `cur_div` cycles apart while `cur_div` is constant.
  - `Move_tick` is never high outside PLAY.
- `Flash_sig` toggles every `FLASH_DIV` cycles in DIE; DIE lasts `FLASH_TOGGLES × FLASH_DIV` cycles.
- Input requirements:
  - Hit flags must remain asserted at least 1 cycle.
  - A `Body_add_sig` pulse that stays high counts once.

## Test plan
Bench parameters for all scenarios: `MOVE_DIV` = 10, `MIN_DIV` = 4, `DIV_STEP` = 2, `APPLES_PER_LEVEL` = 2, `FLASH_DIV` = 5, `FLASH_TOGGLES` = 4.

1. Reset, hold all inputs 0 for 20 cycles → `Game_status` = 001, all other outputs 0, no `Move_tick`.
2. Pulse `Key_right` for 3 cycles → `Game_status` = 010 one cycle after the edge; `Move_tick` pulses every 10 cycles; holding the key causes no further state change.
3. Six separate `Body_add_sig` pulses, one of them 5 cycles long → `Score` = 6, `Level` = 3; tick period shrinks 10 → 8 → 6 → 4 and stays at 4.
4. `Hit_wall_sig` and `Body_add_sig` rising in the same cycle → `Game_status` = 100 next cycle, `Score` unchanged, no `Move_tick` afterwards; `Flash_sig` toggles 4 times 5 cycles apart, then stays 0; `Key_up` edge then returns `Game_status` to 001.
5. Deassert `Rst_n` mid-DIE and mid-PLAY → all outputs return to reset values immediately (asynchronously) and stay there until a fresh key edge.
6. Hold `Key_left` high from DIE through OVER → no return to START until the key is released and pressed again.

Source files
------------

// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game FSM for the snake game; step strobe, score/level,
// death flash and the one-hot game status seen by the snake control module.
module snake_game_sequencer #(
    parameter int unsigned MOVE_DIV         = 12_500_000,
    parameter int unsigned MIN_DIV          = 3_125_000,
    parameter int unsigned DIV_STEP         = 1_250_000,
    parameter int unsigned APPLES_PER_LEVEL = 4,
    parameter int unsigned FLASH_DIV        = 12_500_000,
    parameter int unsigned FLASH_TOGGLES    = 6
) (
    input  logic       Clk_50mhz,
    input  logic       Rst_n,
    input  logic       Key_left,
    input  logic       Key_right,
    input  logic       Key_up,
    input  logic       Key_down,
    input  logic       Body_add_sig,
    input  logic       Hit_wall_sig,
    input  logic       Hit_body_sig,
    output logic [2:0] Game_status,
    output logic       Flash_sig,
    output logic       Move_tick,
    output logic [7:0] Score,
    output logic [3:0] Level
);
    // Low three state bits are the one-hot status; DIE and OVER differ only in bit 3.
    typedef enum logic [3:0] {
        START = 4'b0001,
        PLAY  = 4'b0010,
        DIE   = 4'b0100,
        OVER  = 4'b1100
    } state_t;

    state_t      state;
    logic        key_q, apple_q;
    logic        any_key, key_edge, apple_edge, hit;
    logic [31:0] step_cnt, cur_div, apple_cnt, flash_cnt, toggles;

    assign any_key     = Key_left | Key_right | Key_up | Key_down;
    assign key_edge    = any_key & ~key_q;
    assign apple_edge  = Body_add_sig & ~apple_q;
    assign hit         = Hit_wall_sig | Hit_body_sig;
    assign Game_status = state[2:0];

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= START;
            key_q     <= 1'b0;
            apple_q   <= 1'b0;
            step_cnt  <= '0;
            cur_div   <= MOVE_DIV;
            apple_cnt <= '0;
            flash_cnt <= '0;
            toggles   <= '0;
            Flash_sig <= 1'b0;
            Move_tick <= 1'b0;
            Score     <= '0;
            Level     <= '0;
        end else begin
            key_q   <= any_key;
            apple_q <= Body_add_sig;
            case (state)
                START: begin
                    step_cnt  <= '0;
                    cur_div   <= MOVE_DIV;
                    apple_cnt <= '0;
                    Score     <= '0;
                    Level     <= '0;
                    Flash_sig <= 1'b0;
                    Move_tick <= 1'b0;
                    if (key_edge) state <= PLAY;
                end
                PLAY: begin
                    if (hit) begin
                        state     <= DIE;
                        Move_tick <= 1'b0;
                        flash_cnt <= '0;
                        toggles   <= '0;
                        Flash_sig <= 1'b0;
                    end else begin
                        // >= so a mid-period shrink of cur_div wraps at once instead of skipping a tick
                        Move_tick <= step_cnt >= cur_div - 32'd1;
                        step_cnt  <= (step_cnt >= cur_div - 32'd1) ? '0 : step_cnt + 32'd1;
                        if (apple_edge) begin
                            Score <= (Score == 8'hFF) ? Score : Score + 8'd1;
                            if (apple_cnt >= APPLES_PER_LEVEL - 1) begin
                                apple_cnt <= '0;
                                Level     <= (Level == 4'hF) ? Level : Level + 4'd1;
                                cur_div   <= (cur_div >= MIN_DIV + DIV_STEP) ? cur_div - DIV_STEP : MIN_DIV;
                            end else begin
                                apple_cnt <= apple_cnt + 32'd1;
                            end
                        end
                    end
                end
                DIE: begin
                    Move_tick <= 1'b0;
                    if (flash_cnt >= FLASH_DIV - 1) begin
                        flash_cnt <= '0;
                        toggles   <= toggles + 32'd1;
                        Flash_sig <= (toggles >= FLASH_TOGGLES - 1) ? 1'b0 : ~Flash_sig;
                        if (toggles >= FLASH_TOGGLES - 1) state <= OVER;
                    end else begin
                        flash_cnt <= flash_cnt + 32'd1;
                    end
                end
                OVER: begin
                    Move_tick <= 1'b0;
                    Flash_sig <= 1'b0;
                    if (key_edge) begin
                        state <= START;
                        Score <= '0;
                        Level <= '0;
                    end
                end
                default: state <= START;
            endcase
        end
    end
endmodule
